// File: rtl/arb_rr_4_1.sv
// Four-channel round-robin stream arbiter feeding a registered output stage (winner payload + 2-bit select).
// Latency: one cycle from an input transfer to out_valid; sustains one beat per cycle while out_ready=1.
// Backpressure: with out_valid=1 and out_ready=0 the output register holds and every in_ready bit is 0.
module arb_rr_4_1 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    input  logic             out_ready
);

    // Round-robin pointer: highest-priority channel for the next grant.
    logic [1:0]       ptr_q, ptr_d;
    // Output register.
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_sel_q, out_sel_d;

    // Arbitration results.
    logic             win_vld;
    logic [1:0]       win_idx;
    logic [WIDTH-1:0] win_data;
    logic             load;
    logic             xfer;

    // The output register may accept a new beat when it is empty or being drained this cycle.
    assign load = !out_valid_q || out_ready;

    // A transfer happens exactly when a winner exists and the register can load.
    assign xfer = load && win_vld;

    // Scan channels starting at the pointer; first valid channel wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] idx;
            idx = ptr_q + 2'(k);
            if (!win_vld && in_valid[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    // Select the winner's payload; ungranted channels never reach the output.
    always_comb begin
        win_data = in_data0;
        case (win_idx)
            2'd0:    win_data = in_data0;
            2'd1:    win_data = in_data1;
            2'd2:    win_data = in_data2;
            default: win_data = in_data3;
        endcase
    end

    // One-hot ready to the winner only; forced low while reset is asserted.
    always_comb begin
        in_ready = 4'b0000;
        if (rst_n && xfer) begin
            in_ready[win_idx] = 1'b1;
        end
    end

    // Next-state: reload on a transfer, empty on an idle load cycle, hold on stall.
    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            if (win_vld) begin
                out_valid_d = 1'b1;
                out_data_d  = win_data;
                out_sel_d   = win_idx;
                // Wraps 3 -> 0 by 2-bit arithmetic.
                ptr_d       = win_idx + 2'd1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_rr_4_1.sv
module tb_arb_rr_4_1;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [3:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0] in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_sel;
    logic       out_ready;

    int n_checks = 0;
    int n_errors = 0;

    arb_rr_4_1 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] s, input logic [3:0] d);
        check_eq({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        check_eq({tag, ".sel"},   {30'd0, out_sel},   {30'd0, s});
        check_eq({tag, ".data"},  {28'd0, out_data},  {28'd0, d});
    endtask

    // Hand-computed grant sequences: {sel, data}.
    logic [1:0] rr_sel  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] rr_dat  [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    logic [1:0] sp_sel  [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    logic [3:0] sp_dat  [4] = '{4'h5, 4'h9, 4'h5, 4'h9};
    logic [1:0] xp_sel  [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
    logic [3:0] xp_dat  [4] = '{4'hB, 4'hC, 4'hA, 4'hB};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data0  = 4'hA;
        in_data1  = 4'hB;
        in_data2  = 4'hC;
        in_data3  = 4'hD;
        out_ready = 1'b1;

        // Reset state, with all channels requesting.
        step();
        step();
        check_out("reset", 1'b0, 2'd0, 4'h0);
        check_eq("reset.in_ready", {28'd0, in_ready}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("first.in_ready", {28'd0, in_ready}, 32'h1);

        // Round-robin with all channels valid.
        for (int i = 0; i < 5; i++) begin
            step();
            check_out($sformatf("rr%0d", i), 1'b1, rr_sel[i], rr_dat[i]);
        end

        // Sparse: only channels 1 and 3; pointer is 1 here.
        in_valid = 4'b1010;
        in_data1 = 4'h5;
        in_data3 = 4'h9;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out($sformatf("sparse%0d", i), 1'b1, sp_sel[i], sp_dat[i]);
        end

        // Backpressure: pointer is 0; grant 0,1,2 then stall holding channel 2.
        in_valid = 4'b1111;
        in_data1 = 4'hB;
        in_data3 = 4'hD;
        step();
        step();
        step();
        check_out("bp.pre", 1'b1, 2'd2, 4'hC);
        out_ready = 1'b0;
        #1;
        check_eq("bp.in_ready0", {28'd0, in_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("bp.hold%0d", i), 1'b1, 2'd2, 4'hC);
            check_eq($sformatf("bp.in_ready%0d", i + 1), {28'd0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp.release_ready", {28'd0, in_ready}, 32'h8);
        step();
        check_out("bp.after", 1'b1, 2'd3, 4'hD);

        // Idle gap after a grant to channel 1.
        in_valid = 4'b0010;
        step();
        check_out("idle.grant", 1'b1, 2'd1, 4'hB);
        in_valid = 4'b0000;
        step();
        check_out("idle.gap0", 1'b0, 2'd1, 4'hB);
        step();
        check_out("idle.gap1", 1'b0, 2'd1, 4'hB);
        in_valid = 4'b1111;
        #1;
        check_eq("idle.ptr_probe", {28'd0, in_ready}, 32'h4);
        in_valid = 4'b0001;
        #1;
        check_eq("idle.in_ready", {28'd0, in_ready}, 32'h1);
        step();
        check_out("idle.resume", 1'b1, 2'd0, 4'hA);

        // X payload on an invalid channel; pointer is 1 here.
        in_data3 = 'x;
        in_valid = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out($sformatf("xpay%0d", i), 1'b1, xp_sel[i], xp_dat[i]);
        end

        // Reset mid-stream while a beat is pending under stall.
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("midrst", 1'b0, 2'd0, 4'h0);
        check_eq("midrst.in_ready", {28'd0, in_ready}, 32'h0);
        in_data3  = 4'hD;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("midrst.first_ready", {28'd0, in_ready}, 32'h1);
        step();
        check_out("midrst.grant", 1'b1, 2'd0, 4'hA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
